// File: rtl/mem_access_unit_if.sv
// Data-memory request/ready bus between the MEM-stage access engine and data memory.
// The unit drives one request at a time. It holds that request until the memory answers with dmem_ready.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: byte-lane aligned data-memory access, stall until dmem_ready, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses trap instead of being forced to natural alignment.
module mem_access_unit (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          MEM_control,
  input  logic [1:0]          WB_control,
  input  logic [31:0]         aluout,
  input  logic [31:0]         writedata,
  input  logic [4:0]          rd,
  mem_access_unit_if.master   dmem,
  output logic                mem_stall,
  output logic [31:0]         wb_readdata,
  output logic [31:0]         wb_aluout,
  output logic [4:0]          wb_rd,
  output logic [1:0]          WB_control_out,
  output logic                mem_misalign
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nxt;

  logic        memread, memwrite, memsign;
  logic        is_half, is_byte, is_load, op, issue, trap;
  logic [1:0]  lane;
  logic [3:0]  req_be;
  logic [31:0] req_wdata, req_addr;

  // Request fields captured on entry to WAIT so the bus stays frozen regardless of inputs
  logic        hold_we, hold_half, hold_byte, hold_sign, hold_load;
  logic [1:0]  hold_lane;
  logic [3:0]  hold_be;
  logic [31:0] hold_addr, hold_wdata;

  logic        cur_half, cur_byte, cur_sign, cur_load;
  logic [1:0]  cur_lane;
  logic        req_int, stall_int, complete;
  logic [31:0] lane_data, load_ext;

  assign memread  = MEM_control[4];
  assign memwrite = MEM_control[3];
  assign memsign  = MEM_control[2];
  assign is_half  = (MEM_control[1:0] == 2'b01);
  assign is_byte  = (MEM_control[1:0] == 2'b10);
  assign op       = memread | memwrite;
  assign is_load  = memread & ~memwrite;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = is_half ? aluout[0] : (!is_byte && (aluout[1:0] != 2'b00));
  assign trap  = op & misaligned;
  assign issue = op & ~misaligned;
`else
  assign trap  = 1'b0;
  assign issue = op;
`endif

  always_comb begin
    lane = 2'b00;
    if (is_byte)
      lane = aluout[1:0];
    else if (is_half)
      lane = {aluout[1], 1'b0};
  end

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = writedata;
    if (is_byte) begin
      req_be    = 4'b0001 << lane;
      req_wdata = {4{writedata[7:0]}};
    end else if (is_half) begin
      req_be    = aluout[1] ? 4'b1100 : 4'b0011;
      req_wdata = {2{writedata[15:0]}};
    end
  end

  assign req_addr = {aluout[31:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_int   = 1'b0;
    stall_int = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          req_int = 1'b1;
          if (!dmem.dmem_ready) begin
            stall_int = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        req_int = 1'b1;
        if (dmem.dmem_ready)
          state_nxt = IDLE;
        else
          stall_int = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_we    <= 1'b0;
      hold_half  <= 1'b0;
      hold_byte  <= 1'b0;
      hold_sign  <= 1'b0;
      hold_load  <= 1'b0;
      hold_lane  <= 2'b00;
      hold_be    <= 4'b0000;
      hold_addr  <= 32'h0;
      hold_wdata <= 32'h0;
    end else if (state == IDLE && issue && !dmem.dmem_ready) begin
      hold_we    <= memwrite;
      hold_half  <= is_half;
      hold_byte  <= is_byte;
      hold_sign  <= memsign;
      hold_load  <= is_load;
      hold_lane  <= lane;
      hold_be    <= req_be;
      hold_addr  <= req_addr;
      hold_wdata <= req_wdata;
    end
  end

  assign cur_half = (state == WAIT) ? hold_half : is_half;
  assign cur_byte = (state == WAIT) ? hold_byte : is_byte;
  assign cur_sign = (state == WAIT) ? hold_sign : memsign;
  assign cur_load = (state == WAIT) ? hold_load : is_load;
  assign cur_lane = (state == WAIT) ? hold_lane : lane;

  // Reset overrides the combinational request so an access in flight is dropped immediately
  assign dmem.dmem_req   = req_int & reset;
  assign mem_stall       = stall_int & reset;
  assign dmem.dmem_we    = (state == WAIT) ? hold_we    : memwrite;
  assign dmem.dmem_addr  = (state == WAIT) ? hold_addr  : req_addr;
  assign dmem.dmem_be    = (state == WAIT) ? hold_be    : req_be;
  assign dmem.dmem_wdata = (state == WAIT) ? hold_wdata : req_wdata;

  assign complete  = req_int & dmem.dmem_ready;
  assign lane_data = dmem.dmem_rdata >> {cur_lane, 3'b000};

  always_comb begin
    load_ext = lane_data;
    if (cur_byte)
      load_ext = {{24{cur_sign & lane_data[7]}}, lane_data[7:0]};
    else if (cur_half)
      load_ext = {{16{cur_sign & lane_data[15]}}, lane_data[15:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_readdata    <= 32'h0;
      wb_aluout      <= 32'h0;
      wb_rd          <= 5'd0;
      WB_control_out <= 2'b00;
    end else if (mem_stall) begin
      WB_control_out <= 2'b00;
    end else begin
      wb_aluout      <= aluout;
      wb_rd          <= rd;
      WB_control_out <= trap ? 2'b00 : WB_control;
      wb_readdata    <= (complete && cur_load) ? load_ext : 32'h0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mem_misalign <= 1'b0;
    else if (mem_stall)
      mem_misalign <= 1'b0;
    else
      mem_misalign <= trap;
  end
`else
  assign mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: directed cases, then random accesses with random memory latency.
// The reference model derives lanes, enables and extension from byte counts and shifts.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  MEM_control = 5'd0;
  logic [1:0]  WB_control = 2'd0;
  logic [31:0] aluout = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [4:0]  rd = 5'd0;
  logic        mem_stall;
  logic [31:0] wb_readdata, wb_aluout;
  logic [4:0]  wb_rd;
  logic [1:0]  WB_control_out;
  logic        mem_misalign;

  int n_chk = 0;
  int n_pass = 0;

  mem_access_unit_if dmem_bus();

  mem_access_unit dut (
    .clk            (clk),
    .reset          (reset),
    .MEM_control    (MEM_control),
    .WB_control     (WB_control),
    .aluout         (aluout),
    .writedata      (writedata),
    .rd             (rd),
    .dmem           (dmem_bus),
    .mem_stall      (mem_stall),
    .wb_readdata    (wb_readdata),
    .wb_aluout      (wb_aluout),
    .wb_rd          (wb_rd),
    .WB_control_out (WB_control_out),
    .mem_misalign   (mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  // Reference: access width in bytes decides lane offset, enables, replication and extension
  task automatic model(input logic [4:0] mc, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] rdat, input logic [1:0] wbc,
                       output bit iss, output bit mis, output logic [31:0] addr,
                       output logic [3:0] be, output logic [31:0] wdat,
                       output logic [31:0] rdv, output logic [1:0] wbo);
    int nb, ofs;
    bit op, bad;
    logic [31:0] mask, v;
    nb   = (mc[1:0] == 2'd2) ? 1 : (mc[1:0] == 2'd1) ? 2 : 4;
    ofs  = (nb == 4) ? 0 : (nb == 2) ? 2 * int'(alu[1]) : int'(alu[1:0]);
    bad  = (int'(alu[1:0]) % nb) != 0;
    op   = mc[4] | mc[3];
`ifdef MEM_MISALIGN_TRAP_EN
    iss  = op && !bad;
    mis  = op && bad;
`else
    iss  = op;
    mis  = 1'b0;
`endif
    addr = alu & 32'hFFFF_FFFC;
    be   = 4'(((1 << nb) - 1) << ofs);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    wdat = (nb == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
           (nb == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    v    = (rdat >> (8 * ofs)) & mask;
    if (mc[2] && nb < 4 && v[8 * nb - 1])
      v = v | ~mask;
    rdv  = (iss && mc[4] && !mc[3]) ? v : 32'h0;
    wbo  = mis ? 2'b00 : wbc;
  endtask

  // Called at posedge+1; returns at posedge+1 after the MEM/WB capture of this access
  task automatic run_txn(input logic [4:0] mc, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] r, input logic [1:0] wbc, input int lat,
                         input logic [31:0] rdat);
    bit iss, mis;
    logic [31:0] e_addr, e_wdat, e_rdv;
    logic [3:0]  e_be;
    logic [1:0]  e_wbo;
    int ncyc;
    model(mc, alu, wd, rdat, wbc, iss, mis, e_addr, e_be, e_wdat, e_rdv, e_wbo);
    MEM_control = mc;
    aluout      = alu;
    writedata   = wd;
    rd          = r;
    WB_control  = wbc;
    dmem_bus.dmem_rdata = rdat;
    ncyc = iss ? lat : 0;
    for (int c = 0; c <= ncyc; c++) begin
      dmem_bus.dmem_ready = iss ? (c == lat) : 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("req", 32'(dmem_bus.dmem_req), 32'(iss));
      chk("stall", 32'(mem_stall), 32'(iss && c < lat));
      if (iss) begin
        chk("addr", dmem_bus.dmem_addr, e_addr);
        chk("be", 32'(dmem_bus.dmem_be), 32'(e_be));
        chk("we", 32'(dmem_bus.dmem_we), 32'(mc[3]));
        if (mc[3])
          chk("wdata", dmem_bus.dmem_wdata, e_wdat);
      end
      @(posedge clk);
      #1;
      if (c < ncyc)
        chk("bubble", 32'(WB_control_out), 32'h0);
    end
    dmem_bus.dmem_ready = 1'b0;
    chk("wb_readdata", wb_readdata, e_rdv);
    chk("wb_aluout", wb_aluout, alu);
    chk("wb_rd", 32'(wb_rd), 32'(r));
    chk("wb_ctl", 32'(WB_control_out), 32'(e_wbo));
    chk("misalign", 32'(mem_misalign), 32'(mis));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dmem_bus.dmem_ready = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    MEM_control = 5'b10000;
    aluout      = 32'h100;
    WB_control  = 2'b11;

    // Reset state with a load presented: nothing may leak out
    @(negedge clk);
    chk("rst_req", 32'(dmem_bus.dmem_req), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_wb_ctl", 32'(WB_control_out), 32'h0);
    chk("rst_wb_aluout", wb_aluout, 32'h0);
    chk("rst_misalign", 32'(mem_misalign), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    run_txn(5'b10000, 32'h100, 32'h0, 5'd5, 2'b11, 0, 32'hDEAD_BEEF);
    run_txn(5'b10110, 32'h103, 32'h0, 5'd6, 2'b01, 1, 32'h8011_2233);
    run_txn(5'b10010, 32'h103, 32'h0, 5'd7, 2'b10, 0, 32'h8011_2233);
    run_txn(5'b01001, 32'h102, 32'h0000_ABCD, 5'd8, 2'b11, 3, 32'h0);
    run_txn(5'b10101, 32'h202, 32'h0, 5'd9, 2'b11, 2, 32'h8765_4321);
    run_txn(5'b00000, 32'h1234_5678, 32'h0, 5'd10, 2'b10, 0, 32'hFFFF_FFFF);
    run_txn(5'b11011, 32'h301, 32'h0000_00A5, 5'd11, 2'b01, 1, 32'h0);
    run_txn(5'b10011, 32'h404, 32'h0, 5'd12, 2'b11, 0, 32'hCAFE_F00D);
    run_txn(5'b10000, 32'h102, 32'h0, 5'd13, 2'b11, 1, 32'h1357_9BDF);

    // Reset while waiting on memory aborts the access
    MEM_control = 5'b10000;
    aluout      = 32'h200;
    rd          = 5'd14;
    dmem_bus.dmem_ready = 1'b0;
    @(negedge clk);
    chk("abort_stall0", 32'(mem_stall), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_req_wait", 32'(dmem_bus.dmem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("abort_req", 32'(dmem_bus.dmem_req), 32'h0);
    chk("abort_stall", 32'(mem_stall), 32'h0);
    chk("abort_wb_aluout", wb_aluout, 32'h0);
    chk("abort_wb_rd", 32'(wb_rd), 32'h0);
    chk("abort_wb_readdata", wb_readdata, 32'h0);
    chk("abort_wb_ctl", 32'(WB_control_out), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    run_txn(5'b10000, 32'h300, 32'h0, 5'd15, 2'b11, 0, 32'h0BAD_CAFE);

    for (int i = 0; i < 300; i++) begin
      run_txn(5'($urandom), $urandom, $urandom, 5'($urandom), 2'($urandom),
              int'($urandom_range(0, 3)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
